// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory access sequencer:
//   - mem_state_e   : sequencer state encoding (IDLE, WRITE, READ_WAIT, DONE)
//   - RAM_LAT_MIN/MAX: legal bounds of the RAM read latency parameter
//   - lat_cnt_init  : converts a RAM latency into the READ_WAIT down-counter
//                     start value, clamping out-of-range latencies
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        DONE      = 2'd3
    } mem_state_e;

    localparam int unsigned RAM_LAT_MIN = 32'd1;
    localparam int unsigned RAM_LAT_MAX = 32'd4;

    // The counter starts at latency-1 and the capture happens when it reads
    // zero, so a 2-bit counter covers latencies 1..4. Out-of-range values are
    // clamped so a bad parameter cannot wrap the counter.
    function automatic logic [1:0] lat_cnt_init(input int unsigned lat);
        int unsigned eff;
        if (lat < RAM_LAT_MIN) begin
            eff = RAM_LAT_MIN;
        end else if (lat > RAM_LAT_MAX) begin
            eff = RAM_LAT_MAX;
        end else begin
            eff = lat;
        end
        eff = eff - 32'd1;
        return eff[1:0];
    endfunction

endpackage

// File: rtl/mem_access_seq.sv
// -----------------------------------------------------------------------------
// mem_access_seq
// Sequences single CPU load/store requests onto a synchronous RAM through a
// MAR (address) and MDR (data) register pair.
//
// Store: IDLE -> WRITE (ram_wren=1) -> DONE (done=1) -> IDLE
// Load : IDLE -> READ_WAIT (RAM_LAT cycles) -> DONE (done=1, rdata valid) -> IDLE
//
// Parameters
//   RAM_LAT : RAM read latency in cycles (1..4)
//   AW      : RAM word address width
// Ports
//   Clock      in   single clock, rising edge
//   Clear      in   synchronous active-high reset, highest priority
//   req_valid  in   request present (held by requester until accepted)
//   req_write  in   1 = store, 0 = load
//   req_addr   in   [AW-1:0] word address
//   req_wdata  in   [31:0] store data
//   req_ready  out  high only in IDLE
//   ram_addr   out  [AW-1:0] from MAR
//   ram_data   out  [31:0] from MDR
//   ram_wren   out  RAM write enable, high only in WRITE
//   ram_q      in   [31:0] RAM read data
//   done       out  one-cycle completion pulse
//   rdata      out  [31:0] last load result, held until the next load
//   access_cnt out  [15:0] saturating completed-access count
//                   (present only with MEM_ACCESS_STATS_EN defined)
// -----------------------------------------------------------------------------
module mem_access_seq
    import mem_pkg::*;
#(
    parameter int unsigned RAM_LAT = 32'd1,
    parameter int unsigned AW      = 32'd9
) (
    input  logic          Clock,
    input  logic          Clear,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          req_ready,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_data,
    output logic          ram_wren,
    input  logic [31:0]   ram_q,
    output logic          done,
    output logic [31:0]   rdata
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [15:0]   access_cnt
`endif
);

    localparam logic [1:0] LAT_CNT_INIT = lat_cnt_init(RAM_LAT);

    mem_state_e    state_q,     state_d;
    logic [AW-1:0] mar_q,       mar_d;
    logic [31:0]   mdr_q,       mdr_d;
    logic [31:0]   rdata_q,     rdata_d;
    logic [1:0]    cnt_q,       cnt_d;
    logic          req_ready_q, req_ready_d;
    logic          ram_wren_q,  ram_wren_d;
    logic          done_q,      done_d;
    logic          accept_s;

    assign accept_s = req_valid && req_ready_q;

    // Next-state, MAR/MDR/rdata update and registered output decode.
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    mar_d = req_addr;
                    if (req_write) begin
                        mdr_d   = req_wdata;
                        state_d = WRITE;
                    end else begin
                        cnt_d   = LAT_CNT_INIT;
                        state_d = READ_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d = DONE;
            end
            READ_WAIT: begin
                if (cnt_q == 2'd0) begin
                    // Last latency cycle: RAM data is valid now. rdata is
                    // loaded alongside MDR so it equals MDR during DONE but
                    // is untouched by later stores.
                    mdr_d   = ram_q;
                    rdata_d = ram_q;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - 2'd1;
                    state_d = READ_WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight
        // out of flops in the cycle the state is entered.
        req_ready_d = (state_d == IDLE);
        ram_wren_d  = (state_d == WRITE);
        done_d      = (state_d == DONE);
    end

    // State, address/data registers and registered outputs.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q     <= IDLE;
            mar_q       <= '0;
            mdr_q       <= 32'd0;
            rdata_q     <= 32'd0;
            cnt_q       <= 2'd0;
            req_ready_q <= 1'b1;
            ram_wren_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mar_q       <= mar_d;
            mdr_q       <= mdr_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            ram_wren_q  <= ram_wren_d;
            done_q      <= done_d;
        end
    end

    assign req_ready = req_ready_q;
    assign ram_addr  = mar_q;
    assign ram_data  = mdr_q;
    assign ram_wren  = ram_wren_q;
    assign done      = done_q;
    assign rdata     = rdata_q;

`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] access_cnt_q, access_cnt_d;

    // Count completed accesses, sticking at all-ones.
    always_comb begin
        access_cnt_d = access_cnt_q;
        if (done_q && (access_cnt_q != 16'hFFFF)) begin
            access_cnt_d = access_cnt_q + 16'd1;
        end else begin
            access_cnt_d = access_cnt_q;
        end
    end

    // Access counter register.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            access_cnt_q <= 16'd0;
        end else begin
            access_cnt_q <= access_cnt_d;
        end
    end

    assign access_cnt = access_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_seq.sv
// -----------------------------------------------------------------------------
// tb_mem_access_seq
// Scoreboard bench for mem_access_seq with RAM_LAT=3. The stimulus process
// predicts, at each acceptance, the write strobe and done event it expects
// and pushes them into queues; a monitor pops and compares whenever the DUT
// raises ram_wren or done. A RAM model with the configured read latency is
// attached to the DUT.
// -----------------------------------------------------------------------------
module tb_mem_access_seq;

    localparam int AW      = 9;
    localparam int RAM_LAT = 3;
    localparam int NWORDS  = 16;

    logic          Clock = 1'b0;
    logic          Clear;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          req_ready;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data;
    logic          ram_wren;
    logic [31:0]   ram_q;
    logic          done;
    logic [31:0]   rdata;
`ifdef MEM_ACCESS_STATS_EN
    logic [15:0]   access_cnt;
`endif

    mem_access_seq #(.RAM_LAT(RAM_LAT), .AW(AW)) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_wren  (ram_wren),
        .ram_q     (ram_q),
        .done      (done),
        .rdata     (rdata)
`ifdef MEM_ACCESS_STATS_EN
        ,
        .access_cnt(access_cnt)
`endif
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // ---------------- RAM model (latency RAM_LAT) ----------------
    logic [31:0] ram [0:NWORDS-1];
    logic [31:0] pipe [0:3];
    logic        init_we = 1'b0;
    logic [3:0]  init_a  = 4'd0;
    logic [31:0] init_d  = 32'd0;

    always @(posedge Clock) begin
        if (init_we) ram[init_a] <= init_d;
        else if (ram_wren) ram[ram_addr[3:0]] <= ram_data;
        pipe[0] <= ram[ram_addr[3:0]];
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    always_comb begin
        if (RAM_LAT == 1) ram_q = ram[ram_addr[3:0]];
        else              ram_q = pipe[RAM_LAT-2];
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t exp_done_q[$];
    exp_t exp_wr_q[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every write strobe and done pulse against the queues.
    always @(negedge Clock) begin
        exp_t e;
        if (ram_wren === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                check("unexpected_wren", 32'd1, 32'd0);
            end else begin
                e = exp_wr_q.pop_front();
                check("wren_cycle", cyc, e.cyc);
                check("wren_addr", 32'(ram_addr), 32'(e.addr));
                check("wren_data", ram_data, e.data);
            end
        end
        if (done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_done_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_addr", 32'(ram_addr), 32'(e.addr));
                check("done_rdata", rdata, e.data);
            end
        end
    end

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [0:NWORDS-1];
    logic [31:0] last_rdata;
    int          free_cyc;
    logic [15:0] acc_m;

    // Issue one request after 'gap' idle cycles; called and returns on a negedge.
    task automatic do_access(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                             input int gap, output int acc_cyc);
        bit   accepted = 1'b0;
        int   waited   = 0;
        exp_t e;
        acc_cyc = -1;
        if (gap > 0) begin
            req_valid = 1'b0;
            repeat (gap) @(negedge Clock);
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!accepted && waited < 20) begin
            check("req_ready", 32'(req_ready), 32'(cyc >= free_cyc));
            if (req_ready === 1'b1) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
                if (w) begin
                    ref_mem[a[3:0]] = d;
                    e.cyc = cyc + 1; e.addr = a; e.data = d;
                    exp_wr_q.push_back(e);
                    e.cyc = cyc + 2; e.data = last_rdata;
                    exp_done_q.push_back(e);
                    free_cyc = cyc + 3;
                end else begin
                    last_rdata = ref_mem[a[3:0]];
                    e.cyc = cyc + RAM_LAT + 1; e.addr = a; e.data = last_rdata;
                    exp_done_q.push_back(e);
                    free_cyc = cyc + RAM_LAT + 2;
                end
                if (acc_m != 16'hFFFF) acc_m = acc_m + 16'd1;
            end
            @(negedge Clock);
            waited++;
        end
        req_valid = 1'b0;
        if (!accepted) begin
            n_checks++;
            n_err++;
            $display("FAIL ready_timeout: request not accepted within 20 cycles (cycle %0d)", cyc);
        end
    endtask

    // Wait (bounded) for all expected events to be observed.
    task automatic drain();
        int n = 0;
        while ((exp_done_q.size() != 0 || exp_wr_q.size() != 0) && n < 30) begin
            @(negedge Clock);
            n++;
        end
        @(negedge Clock);
        check("sb_done_empty", exp_done_q.size(), 32'd0);
        check("sb_wr_empty", exp_wr_q.size(), 32'd0);
        exp_done_q.delete();
        exp_wr_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_ram_wren"},  32'(ram_wren),  32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
        check({tag, "_ram_data"},  ram_data,       32'd0);
        check({tag, "_rdata"},     rdata,          32'd0);
    endtask

    initial begin
        int a_cyc;
        bit w;
        logic [AW-1:0] a;
        logic [31:0] d;

        Clear = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = 32'd0;
        last_rdata = 32'd0; acc_m = 16'd0;

        // Preload RAM and the reference copy while Clear is held.
        @(negedge Clock);
        for (int i = 0; i < NWORDS; i++) begin
            ref_mem[i] = $urandom;
            init_we = 1'b1; init_a = 4'(i); init_d = ref_mem[i];
            @(negedge Clock);
        end
        init_we = 1'b0;
        @(negedge Clock);
        Clear = 1'b0;
        check_reset_outputs("reset");
        free_cyc = cyc;

        // Directed store then load of the same word.
        do_access(1'b1, 9'h005, 32'hDEADBEEF, 0, a_cyc);
        do_access(1'b0, 9'h005, 32'd0, 1, a_cyc);
        drain();

        // Load then a store: store must not disturb rdata. Requests back-to-back.
        do_access(1'b1, 9'h007, 32'hCAFEF00D, 0, a_cyc);
        do_access(1'b0, 9'h007, 32'd0, 0, a_cyc);
        do_access(1'b1, 9'h009, 32'h12345678, 0, a_cyc);
        drain();
        check("rdata_after_store", rdata, 32'hCAFEF00D);

        // Clear during the WRITE cycle of a store aborts it.
        do_access(1'b1, 9'h003, 32'hA5A5A5A5, 0, a_cyc);
        exp_done_q.delete();
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        check_reset_outputs("abort");
        last_rdata = 32'd0; acc_m = 16'd0; free_cyc = cyc;
        repeat (3) begin
            @(negedge Clock);
            check("abort_no_done", 32'(done), 32'd0);
        end
        exp_wr_q.delete();

        // Randomised traffic.
        for (int k = 0; k < 40; k++) begin
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, NWORDS - 1));
            d = $urandom;
            do_access(w, a, d, $urandom_range(0, 2), a_cyc);
        end
        drain();

`ifdef MEM_ACCESS_STATS_EN
        check("access_cnt", 32'(access_cnt), 32'(acc_m));
        dut.access_cnt_q = 16'hFFFE;
        acc_m = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            do_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, NWORDS - 1)), $urandom, 0, a_cyc);
        end
        drain();
        check("access_cnt_sat", 32'(access_cnt), 32'(acc_m));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
